// File: rtl/blur_frame_ctrl.sv
// Frame sequencer for the blur/DoG/keypoint datapath: raster tracking, line-buffer
// write control, interior-window flags, latency-aligned out_valid and frame drain.
module blur_frame_ctrl #(
  parameter int unsigned COLS  = 640,
  parameter int unsigned ROWS  = 480,
  parameter int unsigned COL_W = 10,
  parameter int unsigned ROW_W = 9,
  parameter int unsigned LAT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             pix_valid,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             lb_wr_en,
  output logic             win3_valid,
  output logic             win5_valid,
  output logic             win7_valid,
  output logic             out_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned DRW = $clog2(LAT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_e;

  state_e           state_q;
  logic [COL_W-1:0] col_q, col_d, pix_col_q;
  logic [ROW_W-1:0] row_q, row_d, pix_row_q;
  logic [DRW-1:0]   drain_q;
  logic [LAT-1:0]   dly_q;
  logic             pix_valid_q, win3_q, win5_q, win7_q;
  logic             frame_done_q, busy_q, overrun_q;
  logic             accept, last_col, last_row;

  assign accept   = in_valid && (state_q != FLUSH);
  assign last_col = (col_q == COL_W'(COLS - 1));
  assign last_row = (row_q == ROW_W'(ROWS - 1));

  // Wrapping from the last pixel returns both counters to 0 for the next frame.
  always_comb begin
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (last_col) begin
      col_d = '0;
      row_d = last_row ? '0 : row_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      pix_col_q    <= '0;
      pix_row_q    <= '0;
      drain_q      <= '0;
      pix_valid_q  <= 1'b0;
      win3_q       <= 1'b0;
      win5_q       <= 1'b0;
      win7_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      pix_valid_q  <= accept;
      frame_done_q <= 1'b0;
      win3_q <= accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
      win5_q <= accept && (row_q >= ROW_W'(4)) && (col_q >= COL_W'(4));
      win7_q <= accept && (row_q >= ROW_W'(6)) && (col_q >= COL_W'(6));
      if (accept) begin
        pix_col_q <= col_q;
        pix_row_q <= row_q;
        col_q     <= col_d;
        row_q     <= row_d;
      end

      case (state_q)
        IDLE: begin
          if (in_valid) begin
            overrun_q <= 1'b0;
            busy_q    <= 1'b1;
            if (last_col && last_row) begin
              state_q <= FLUSH;
              drain_q <= DRW'(LAT);
            end else begin
              state_q <= STREAM;
            end
          end
        end
        STREAM: begin
          if (in_valid && last_col && last_row) begin
            state_q <= FLUSH;
            drain_q <= DRW'(LAT);
          end
        end
        FLUSH: begin
          if (in_valid) overrun_q <= 1'b1;
          // Leaving on the edge after the counter hits zero lines frame_done up
          // one cycle after the last pixel's out_valid.
          if (drain_q == '0) begin
            state_q      <= IDLE;
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
          end else begin
            drain_q <= drain_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Free-running delay line: shifts every cycle irrespective of FSM state.
  generate
    if (LAT > 1) begin : g_dly_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= {dly_q[LAT-2:0], win7_q};
      end
    end else begin : g_dly_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= win7_q;
      end
    end
  endgenerate

  assign pix_valid  = pix_valid_q;
  assign lb_wr_en   = pix_valid_q;
  assign pix_col    = pix_col_q;
  assign pix_row    = pix_row_q;
  assign win3_valid = win3_q;
  assign win5_valid = win5_q;
  assign win7_valid = win7_q;
  assign out_valid  = dly_q[LAT-1];
  assign frame_done = frame_done_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
